// File: rtl/tdm_demux_pkg.sv
// Shared constants, types and slicing helper for the four-lane TDM demultiplexer.
package tdm_demux_pkg;

   localparam int NUM_CH = 4;
   localparam int SLOT_W = 2;

   typedef logic [SLOT_W-1:0] slot_t;

   // Low bit index of a lane word inside the packed ch_data bus.
   function automatic int lane_slice(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/tdm_deser_lane.sv
// One deserialiser lane: shifts accepted bits into a word and publishes it
// with a one-cycle valid pulse once WIDTH bits have arrived.
module tdm_deser_lane #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_en,
   input  logic             clr,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [WIDTH-1:0] shift_r, shift_base_s, shifted_s, shift_nxt_s;
   logic [WIDTH-1:0] word_r, word_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_base_s, cnt_nxt_s;
   logic             valid_r, valid_nxt_s;

   // Next-state: a clear discards the partial word before the current bit lands.
   always_comb begin
      shift_base_s = shift_r;
      cnt_base_s   = cnt_r;
      shifted_s    = shift_r;
      shift_nxt_s  = shift_r;
      cnt_nxt_s    = cnt_r;
      word_nxt_s   = word_r;
      valid_nxt_s  = 1'b0;
      if (clr) begin
         shift_base_s = {WIDTH{1'b0}};
         cnt_base_s   = CNT_ZERO;
      end else begin
         shift_base_s = shift_r;
         cnt_base_s   = cnt_r;
      end
      if (MSB_FIRST) begin
         shifted_s = {shift_base_s[WIDTH-2:0], bit_in};
      end else begin
         shifted_s = {bit_in, shift_base_s[WIDTH-1:1]};
      end
      if (bit_en && (cnt_base_s == CNT_LAST)) begin
         word_nxt_s  = shifted_s;
         valid_nxt_s = 1'b1;
         cnt_nxt_s   = CNT_ZERO;
         shift_nxt_s = {WIDTH{1'b0}};
      end else if (bit_en) begin
         cnt_nxt_s   = cnt_base_s + CNT_ONE;
         shift_nxt_s = shifted_s;
      end else begin
         cnt_nxt_s   = cnt_base_s;
         shift_nxt_s = shift_base_s;
      end
   end

   // Lane state and published word registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r <= {WIDTH{1'b0}};
         cnt_r   <= CNT_ZERO;
         word_r  <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
      end else begin
         shift_r <= shift_nxt_s;
         cnt_r   <= cnt_nxt_s;
         word_r  <= word_nxt_s;
         valid_r <= valid_nxt_s;
      end
   end

   assign word       = word_r;
   assign word_valid = valid_r;
   assign busy       = (cnt_r != CNT_ZERO);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer front end: round-robin slot counter, lane
// routing decode, sticky framing error and four deserialiser lanes.
module tdm_demux4
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i,
   input  logic                  in_valid,
   input  logic                  frame_sync,
   output logic [SLOT_W-1:0]     s,
   output logic [NUM_CH*WIDTH-1:0] ch_data,
   output logic [NUM_CH-1:0]     ch_valid,
   output logic                  frame_err
);

   slot_t             s_r, s_nxt_s, lane_sel_s;
   logic              frame_err_r, frame_err_nxt_s;
   logic              sync_s;
   logic [NUM_CH-1:0] dec_s, bit_en_s, busy_s, word_valid_s;

   // Slot advance, lane routing and framing error detection.
   always_comb begin
      sync_s          = in_valid & frame_sync;
      s_nxt_s         = s_r;
      lane_sel_s      = s_r;
      frame_err_nxt_s = frame_err_r;
      if (in_valid) begin
         if (frame_sync) begin
            lane_sel_s = 2'd0;
            s_nxt_s    = 2'd1;
            if ((|busy_s) || (s_r != 2'd0)) begin
               frame_err_nxt_s = 1'b1;
            end else begin
               frame_err_nxt_s = frame_err_r;
            end
         end else begin
            lane_sel_s = s_r;
            s_nxt_s    = s_r + 2'd1;
         end
      end else begin
         s_nxt_s = s_r;
      end
      case (lane_sel_s)
         2'd0:    dec_s = 4'b0001;
         2'd1:    dec_s = 4'b0010;
         2'd2:    dec_s = 4'b0100;
         2'd3:    dec_s = 4'b1000;
         default: dec_s = 4'b0000;
      endcase
      if (in_valid) begin
         bit_en_s = dec_s;
      end else begin
         bit_en_s = 4'b0000;
      end
   end

   // Slot counter and sticky frame error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r         <= 2'd0;
         frame_err_r <= 1'b0;
      end else begin
         s_r         <= s_nxt_s;
         frame_err_r <= frame_err_nxt_s;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      localparam int LO = lane_slice(k, WIDTH);
      tdm_deser_lane #(
         .WIDTH     (WIDTH),
         .MSB_FIRST (MSB_FIRST)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .bit_in     (i),
         .bit_en     (bit_en_s[k]),
         .clr        (sync_s),
         .word       (ch_data[LO +: WIDTH]),
         .word_valid (word_valid_s[k]),
         .busy       (busy_s[k])
      );
   end

   assign s         = s_r;
   assign ch_valid  = word_valid_s;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed-plus-random bench for tdm_demux4 against a word-level reference model,
// with MSB-first and LSB-first instances driven from the same stream.
module tb_tdm_demux4;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i = 1'b0, in_valid = 1'b0, frame_sync = 1'b0;
   logic [1:0]     s, s_l;
   logic [4*W-1:0] ch_data, ch_data_l;
   logic [3:0]     ch_valid, ch_valid_l;
   logic           frame_err, frame_err_l;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: accepted bits collected per lane, words as integers.
   int         m_bits [4][W];
   int         m_cnt [4];
   logic [W-1:0] m_msb [4];
   logic [W-1:0] m_lsb [4];
   logic [3:0] m_valid;
   int         m_slot;
   logic       m_err;

   always #5 clk = ~clk;

   tdm_demux4 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .i(i), .in_valid(in_valid), .frame_sync(frame_sync),
      .s(s), .ch_data(ch_data), .ch_valid(ch_valid), .frame_err(frame_err));

   tdm_demux4 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_n(rst_n), .i(i), .in_valid(in_valid), .frame_sync(frame_sync),
      .s(s_l), .ch_data(ch_data_l), .ch_valid(ch_valid_l), .frame_err(frame_err_l));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_cnt[k] = 0;
         m_msb[k] = '0;
         m_lsb[k] = '0;
      end
      m_valid = 4'b0000;
      m_slot  = 0;
      m_err   = 1'b0;
   endtask

   task automatic model_step(input logic iv, input logic fs, input logic b);
      int lane;
      logic [W-1:0] wm, wl;
      m_valid = 4'b0000;
      if (iv) begin
         if (fs) begin
            if (m_slot != 0 || m_cnt[0] != 0 || m_cnt[1] != 0 || m_cnt[2] != 0 || m_cnt[3] != 0)
               m_err = 1'b1;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            lane   = 0;
            m_slot = 1;
         end else begin
            lane   = m_slot;
            m_slot = (m_slot + 1) % 4;
         end
         m_bits[lane][m_cnt[lane]] = int'(b);
         m_cnt[lane]++;
         if (m_cnt[lane] == W) begin
            wm = '0;
            wl = '0;
            for (int j = 0; j < W; j++) begin
               wm = wm | (W'(m_bits[lane][j]) << (W - 1 - j));
               wl = wl | (W'(m_bits[lane][j]) << j);
            end
            m_msb[lane]   = wm;
            m_lsb[lane]   = wl;
            m_valid[lane] = 1'b1;
            m_cnt[lane]   = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".s"},        64'(s),          64'(m_slot));
      chk({tag, ".valid"},    64'(ch_valid),   64'(m_valid));
      chk({tag, ".data"},     64'(ch_data),    64'({m_msb[3], m_msb[2], m_msb[1], m_msb[0]}));
      chk({tag, ".err"},      64'(frame_err),  64'(m_err));
      chk({tag, ".s_l"},      64'(s_l),        64'(m_slot));
      chk({tag, ".valid_l"},  64'(ch_valid_l), 64'(m_valid));
      chk({tag, ".data_l"},   64'(ch_data_l),  64'({m_lsb[3], m_lsb[2], m_lsb[1], m_lsb[0]}));
      chk({tag, ".err_l"},    64'(frame_err_l), 64'(m_err));
   endtask

   task automatic step(input string tag, input logic iv, input logic fs, input logic b);
      in_valid   = iv;
      frame_sync = fs;
      i          = b;
      @(posedge clk);
      model_step(iv, fs, b);
      #1;
      check_all(tag);
   endtask

   logic [7:0] t1w [4];
   int         pulses [4];
   logic       b;

   initial begin
      t1w = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: interleaved known words, continuous
      for (int n = 0; n < 32; n++) begin
         b = t1w[n % 4][7 - n / 4];
         step("t1", 1'b1, (n == 0), b);
         if (n >= 28) chk("t1.order", 64'(ch_valid), 64'(4'b0001 << (n - 28)));
         else         chk("t1.quiet", 64'(ch_valid), 64'd0);
      end
      chk("t1.words", 64'(ch_data), 64'h00FF3CA5);
      chk("t1.err", 64'(frame_err), 64'd0);

      // 2: same stream with in_valid gaps; junk on i/frame_sync during gaps
      for (int n = 0; n < 32; n++) begin
         b = t1w[n % 4][7 - n / 4];
         step("t2", 1'b1, (n == 0), b);
         step("t2g", 1'b0, 1'($urandom % 2), 1'($urandom % 2));
      end
      chk("t2.words", 64'(ch_data), 64'h00FF3CA5);

      // 3: frame_sync at accepted bit 13, then a clean frame
      for (int n = 0; n < 13; n++) step("t3a", 1'b1, (n == 0), 1'($urandom % 2));
      step("t3s", 1'b1, 1'b1, 1'($urandom % 2));
      chk("t3.err", 64'(frame_err), 64'd1);
      for (int n = 1; n < 32; n++) begin
         if ($urandom % 4 == 0) step("t3g", 1'b0, 1'b0, 1'($urandom % 2));
         step("t3b", 1'b1, 1'b0, 1'($urandom % 2));
      end

      // 4: async reset mid-frame at bit 20
      for (int n = 0; n < 20; n++) step("t4a", 1'b1, (n == 0), 1'($urandom % 2));
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t4.s0", 64'(s), 64'd0);
      chk("t4.v0", 64'(ch_valid), 64'd0);
      chk("t4.d0", 64'(ch_data), 64'd0);
      chk("t4.e0", 64'(frame_err), 64'd0);
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int n = 0; n < 32; n++) step("t4b", 1'b1, 1'b0, 1'($urandom % 2));

      // 5: lane 0 receives 1,0,0,0,0,0,0,0
      for (int n = 0; n < 32; n++) begin
         if (n % 4 == 0) b = (n == 0);
         else            b = 1'($urandom % 2);
         step("t5", 1'b1, (n == 0), b);
      end
      chk("t5.lsb", 64'(ch_data_l[7:0]), 64'h01);
      chk("t5.msb", 64'(ch_data[7:0]), 64'h80);

      // 6: 64 continuous bits, wrap and pulse counts
      for (int k = 0; k < 4; k++) pulses[k] = 0;
      for (int n = 0; n < 64; n++) begin
         step("t6", 1'b1, (n == 0), 1'($urandom % 2));
         chk("t6.s", 64'(s), 64'((n + 1) % 4));
         for (int k = 0; k < 4; k++) pulses[k] += int'(ch_valid[k]);
      end
      for (int k = 0; k < 4; k++) chk("t6.pulses", 64'(pulses[k]), 64'd2);
      chk("t6.err", 64'(frame_err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Time-division demultiplexer front end. It takes a serial bit stream, steers successive bits round-robin into four channel lanes, and assembles each lane into a WIDTH-bit parallel word. It generates the 2-bit channel select that the downstream 1-to-4 demux stage consumes. A per-channel valid pulse marks each completed word.

Parameters:
WIDTH, 8, bits per channel word (legal range 2..32)
MSB_FIRST, 1, 1 = first received bit of a word lands in bit WIDTH-1; 0 = first bit lands in bit 0

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
i  input  1  serial data bit
in_valid  input  1  i is valid this cycle; the bit is accepted when in_valid=1
frame_sync  input  1  frame start marker; qualifies the bit presented in the same cycle as slot 0 of a new frame
s  output  2  current slot/channel select (registered); drives the downstream demux select
ch_data  output  4*WIDTH  lane words; lane k occupies [k*WIDTH +: WIDTH]
ch_valid  output  4  one-cycle pulse per lane when ch_data for that lane is updated
frame_err  output  1  sticky flag: frame_sync arrived while any lane held a partial word

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous deassert from the system's point of view):
  - s=0, ch_data=0, ch_valid=0, frame_err=0.
  - All lane bit counters and shift registers = 0.
- Slot counter s:
  - Advances by 1 (modulo 4, 3->0 wrap) on each accepted bit.
  - Holds when in_valid=0.
- Accepted bit routing:
  - Without frame_sync, the bit goes to lane s.
  - With frame_sync=1, the bit goes to lane 0 and s becomes 1 next cycle.
- Lane assembly:
  - Each lane has a shift register and a bit counter 0..WIDTH-1.
  - Each accepted bit routed to the lane shifts in per MSB_FIRST and increments the counter.
  - When the counter reaches WIDTH-1 and the lane accepts a bit:
    - The next cycle, ch_data[lane] holds the full word (including that bit).
    - ch_valid[lane]=1 for exactly one cycle.
    - The lane counter returns to 0.
  - Latency: 1 clock from the accepting edge of the final bit to ch_valid.
  - ch_data[lane] holds its value until that lane's next completed word.
- Throughput: one bit per cycle.
  - Lane 0 completes at accepted bit 4*(WIDTH-1)+1 of a frame, lane 3 at bit 4*WIDTH.
  - ch_valid pulses for different lanes never coincide under continuous input.
- frame_sync handling:
  - Clears all lane counters and discards partial words. ch_data is unchanged.
  - The qualifying bit then becomes bit 0 of lane 0.
  - If any lane counter was nonzero, or s was nonzero, frame_err is set.
  - frame_err clears only on reset.
  - frame_sync with in_valid=0 is ignored.
- Stalls: in_valid gaps of any length freeze all state; there is no timeout.
- Reset mid-word: all partial data is lost; the first accepted bit after reset is lane 0 bit 0.

Decomposition:
- Package tdm_demux_pkg:
  - NUM_CH=4
  - SLOT_W=2
  - typedef slot_t (logic [SLOT_W-1:0])
  - function lane_slice index helper
- One sub-module, tdm_deser_lane, instantiated 4 times in a generate loop.
  - Holds the shift register, bit counter, word register and valid pulse.
  - Inputs: bit_in, bit_en, clr.
  - Outputs: word, word_valid, busy (counter!=0).
- Top level holds the slot counter, routing decode (the inverse of the downstream demux select) and frame_err.

Test Plan:
1. Reset release, then 32 continuous bits with frame_sync on the first, WIDTH=8, MSB_FIRST=1, stream 0xA5,0x3C,0xFF,0x00 interleaved bitwise (bit n -> lane n%4):
   - ch_valid pulses in order 1,2,4,8 on consecutive cycles.
   - ch_data = {0x00,0xFF,0x3C,0xA5}.
   - frame_err=0.
2. Same stream with in_valid toggling 1/0 every cycle:
   - Identical words.
   - s holds during gaps.
   - Completion spacing is 2 cycles.
3. frame_sync asserted at accepted bit 13 of a frame:
   - frame_err=1.
   - No ch_valid for the discarded partial words.
   - The following 32 bits complete cleanly into new words.
4. rst_n pulled low for 1 cycle mid-frame (bit 20), asynchronously between edges:
   - Outputs zero immediately.
   - The next frame with no frame_sync assembles correctly from lane 0.
5. MSB_FIRST=0 with lane 0 receiving bits 1,0,0,0,0,0,0,0 -> ch_data lane 0 = 0x01.
6. Wrap check, 64 continuous bits with frame_sync only on the first:
   - s sequence 0,1,2,3,0 repeats.
   - Each lane pulses ch_valid exactly twice.
